param_uni_shift_reg: RTL and testbench
======================================

Name: param_uni_shift_reg

Overview:
- WIDTH-bit universal shift register. Eight per-cycle modes: hold, logical shift right/left, parallel load, rotate right/left, arithmetic shift right, synchronous clear.
- Built-in burst engine: loads a word, then shifts it out serially for a programmed number of cycles without per-cycle mode control.
- Sits between parallel datapaths and bit-serial links (SPI-style framing, serialisers, test scan).

Parameters:
- WIDTH, 8, register width; legal range is 2 or more.
- CNT_W, 4, width of burst_len; must hold WIDTH, so 2**CNT_W-1 >= WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  clock enable. Gates mode operations and burst progress.
- mode  in  3  operation select in IDLE: 0 HOLD, 1 SHR, 2 SHL, 3 LOAD, 4 ROR, 5 ROL, 6 ASR, 7 CLR.
- ser_inr  in  1  serial input entering at the MSB on right shifts.
- ser_inl  in  1  serial input entering at the LSB on left shifts.
- par_in  in  WIDTH  parallel load data.
- start  in  1  burst request, single-cycle strobe.
- burst_len  in  CNT_W  number of shifts in a burst; sampled with start.
- burst_dir  in  1  burst direction: 0 right (serial out at LSB), 1 left (serial out at MSB); sampled with start.
- par_out  out  WIDTH  register contents q.
- ser_outr  out  1  q[0] while a right-direction operation is selected, else 0.
- ser_outl  out  1  q[WIDTH-1] while a left-direction operation is selected, else 0.
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, any time, including mid-burst): q=0, state=IDLE, counter=0, latched dir=0, busy=0, done=0. Outputs reflect this immediately.
- States: IDLE, BURST. Only state, q, counter, latched dir and done are registered.
- IDLE, en=1, start=0, by mode:
  - HOLD: q unchanged.
  - SHR: q <= {ser_inr, q[WIDTH-1:1]}.
  - SHL: q <= {q[WIDTH-2:0], ser_inl}.
  - LOAD: q <= par_in.
  - ROR: q <= {q[0], q[WIDTH-1:1]}.
  - ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - CLR: q <= 0.
- IDLE, en=0: q held and start ignored.
- IDLE, en=1, start=1: start takes priority over mode.
  - q <= par_in; dir latched from burst_dir; counter <= burst_len.
  - burst_len != 0: go to BURST.
  - burst_len == 0: stay IDLE; done=1 on the next cycle.
- BURST, en=1: shift one bit per cycle and decrement the counter.
  - dir=0: q <= {ser_inr, q[WIDTH-1:1]}.
  - dir=1: q <= {q[WIDTH-2:0], ser_inl}.
  - On the shift that takes the counter 1->0: return to IDLE; done=1 on the following cycle (the first IDLE cycle).
- BURST, en=0: q and counter frozen; burst resumes when en returns.
- In BURST, mode and start are ignored (a new start is dropped, not queued).
- busy = (state==BURST). A burst of N shifts holds busy high for exactly N enabled cycles after the start cycle.
- done is registered, high for exactly one cycle, and never asserts without a prior accepted start.
- ser_outr / ser_outl are combinational from q, state, mode and latched dir:
  - ser_outr = q[0] when (IDLE and mode in {SHR, ROR, ASR}) or (BURST and dir=0); else 0.
  - ser_outl = q[WIDTH-1] when (IDLE and mode in {SHL, ROL}) or (BURST and dir=1); else 0.
  - Consequence: the bit shifted out on each edge is visible on the serial output during the cycle before that edge.
- burst_len > WIDTH is legal: after WIDTH shifts, the serial-in bits shift out.
- Width rules: no arithmetic on q. The counter is CNT_W bits and decrement-only, so it never wraps.

Test Plan (WIDTH=8):
- Reset mid-burst: load 0xA5, start burst_len=8, assert rst after 3 shifts -> par_out=0x00, busy=0, done=0 immediately. After release, mode=HOLD keeps 0x00.
- Per-mode check: from 0x96 with ser_inr=1, ser_inl=0:
  - SHR -> 0xCB; SHL -> 0x2C; ROR -> 0x4B; ROL -> 0x2D.
  - ASR on 0x96 -> 0xCB; ASR on 0x16 -> 0x0B.
  - CLR -> 0x00; LOAD 0x3C -> 0x3C.
  - en=0 with any mode -> unchanged.
- Right burst: start with par_in=0xB4, burst_len=8, dir=0, ser_inr=0 -> ser_outr sequence LSB-first 0,0,1,0,1,1,0,1; busy high 8 cycles; done pulses once; final par_out=0x00.
- Left burst with stall: par_in=0xB4, burst_len=4, dir=1, ser_inl=1, en low for 2 cycles mid-burst -> ser_outl sequence 1,0,1,1; busy high 6 cycles; final par_out=0x4F.
- Edge cases: burst_len=0 -> par_out=par_in, busy stays 0, done pulses the next cycle. A start issued during BURST is ignored, and only one done pulse follows.
- Over-length burst: burst_len=10, dir=0, ser_inr=1, par_in=0x00 -> ser_outr sequence 0 x8 then 1,1; final par_out=0xFF.

Source files
------------

// File: rtl/param_uni_shift_reg.sv
// Universal shift register with eight per-cycle modes and a load-then-shift burst engine
// that serialises a word for a programmed number of clock-enabled cycles.
module param_uni_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_inr,
  input  logic             ser_inl,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_outr,
  output logic             ser_outl,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHR  = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_LOAD = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_ROL  = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (start) begin
            // start outranks mode; a zero-length burst completes without leaving IDLE
            q_d   = par_in;
            dir_d = burst_dir;
            cnt_d = burst_len;
            if (burst_len != '0) state_d = BURST;
            else                 done_d  = 1'b1;
          end else begin
            case (mode)
              M_HOLD:  q_d = q_q;
              M_SHR:   q_d = {ser_inr, q_q[WIDTH-1:1]};
              M_SHL:   q_d = {q_q[WIDTH-2:0], ser_inl};
              M_LOAD:  q_d = par_in;
              M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
              M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              M_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              M_CLR:   q_d = '0;
              default: q_d = q_q;
            endcase
          end
        end
      end
      BURST: begin
        if (en) begin
          q_d   = dir_q ? {q_q[WIDTH-2:0], ser_inl} : {ser_inr, q_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs expose the bit that the next enabled edge will shift out.
  always_comb begin
    ser_outr = 1'b0;
    ser_outl = 1'b0;
    if (state_q == BURST) begin
      ser_outr = !dir_q & q_q[0];
      ser_outl =  dir_q & q_q[WIDTH-1];
    end else begin
      if (mode == M_SHR || mode == M_ROR || mode == M_ASR) ser_outr = q_q[0];
      if (mode == M_SHL || mode == M_ROL)                  ser_outl = q_q[WIDTH-1];
    end
  end

  assign par_out = q_q;
  assign busy    = (state_q == BURST);
  assign done    = done_q;

endmodule

// File: tb/tb_param_uni_shift_reg.sv
// Directed bench for param_uni_shift_reg (WIDTH=8): per-mode vector table plus
// hand-written burst, stall, reset and edge-case sequences.
module tb_param_uni_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       ser_inr, ser_inl;
  logic [7:0] par_in;
  logic       start;
  logic [3:0] burst_len;
  logic       burst_dir;
  logic [7:0] par_out;
  logic       ser_outr, ser_outl, busy, done;

  int tests = 0;
  int fails = 0;

  param_uni_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ser_inr(ser_inr), .ser_inl(ser_inl),
    .par_in(par_in), .start(start), .burst_len(burst_len), .burst_dir(burst_dir),
    .par_out(par_out), .ser_outr(ser_outr), .ser_outl(ser_outl), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] mode;
    logic       en;
    logic [7:0] init;
    logic [7:0] exp_q;
    logic       exp_sr;
    logic       exp_sl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start, then walk ncyc BURST cycles with a per-cycle enable pattern,
  // checking the serial output, busy and done each cycle, then the completion.
  task automatic do_burst(input string nm, input logic [7:0] pin, input logic [3:0] len,
                          input logic dir, input logic sr, input logic sl,
                          input logic [15:0] en_pat, input logic [15:0] exp_ser,
                          input int ncyc, input logic [7:0] exp_final);
    en = 1'b1; mode = 3'd0; start = 1'b1; par_in = pin; burst_len = len;
    burst_dir = dir; ser_inr = sr; ser_inl = sl;
    step();
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      en = en_pat[c];
      #1;
      chk($sformatf("%s ser[%0d]", nm, c), dir ? ser_outl : ser_outr, exp_ser[c]);
      chk($sformatf("%s busy[%0d]", nm, c), busy, 1'b1);
      chk($sformatf("%s done[%0d]", nm, c), done, 1'b0);
      step();
    end
    en = 1'b1;
    chk({nm, " busy_end"}, busy, 1'b0);
    chk({nm, " done_pulse"}, done, 1'b1);
    chk({nm, " final_q"}, par_out, exp_final);
    step();
    chk({nm, " done_clear"}, done, 1'b0);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'd1, 1'b1, 8'h96, 8'hCB, 1'b0, 1'b0};
    vecs[1]  = '{3'd2, 1'b1, 8'h96, 8'h2C, 1'b0, 1'b1};
    vecs[2]  = '{3'd4, 1'b1, 8'h96, 8'h4B, 1'b0, 1'b0};
    vecs[3]  = '{3'd5, 1'b1, 8'h96, 8'h2D, 1'b0, 1'b1};
    vecs[4]  = '{3'd6, 1'b1, 8'h96, 8'hCB, 1'b0, 1'b0};
    vecs[5]  = '{3'd6, 1'b1, 8'h16, 8'h0B, 1'b0, 1'b0};
    vecs[6]  = '{3'd7, 1'b1, 8'h96, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 1'b1, 8'h96, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 1'b1, 8'h96, 8'h96, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 1'b0, 8'h96, 8'h96, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 1'b0, 8'h96, 8'h96, 1'b0, 1'b0};
    vecs[11] = '{3'd4, 1'b1, 8'h97, 8'hCB, 1'b1, 1'b0};
    vecs[12] = '{3'd5, 1'b1, 8'h97, 8'h2F, 1'b0, 1'b1};
    vecs[13] = '{3'd2, 1'b1, 8'h69, 8'hD2, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; mode = 3'd0; ser_inr = 1'b0; ser_inl = 1'b0;
    par_in = 8'h00; start = 1'b0; burst_len = 4'd0; burst_dir = 1'b0;
    #1;
    chk("reset par_out", par_out, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    step(); step();
    rst = 1'b0;
    step();

    // Per-mode table
    for (int i = 0; i < 14; i++) begin
      en = 1'b1; mode = 3'd3; par_in = vecs[i].init; start = 1'b0;
      step();
      mode = vecs[i].mode; en = vecs[i].en; par_in = 8'h3C;
      ser_inr = 1'b1; ser_inl = 1'b0;
      #1;
      chk($sformatf("vec%0d mode%0d ser_outr", i, vecs[i].mode), ser_outr, vecs[i].exp_sr);
      chk($sformatf("vec%0d mode%0d ser_outl", i, vecs[i].mode), ser_outl, vecs[i].exp_sl);
      step();
      chk($sformatf("vec%0d mode%0d par_out", i, vecs[i].mode), par_out, vecs[i].exp_q);
      chk($sformatf("vec%0d busy", i), busy, 1'b0);
    end

    // Right burst: LSB-first 0,0,1,0,1,1,0,1 then zeros shifted in
    do_burst("right", 8'hB4, 4'd8, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h00B4, 8, 8'h00);

    // Left burst with two stalled cycles after two shifts
    do_burst("left_stall", 8'hB4, 4'd4, 1'b1, 1'b0, 1'b1, 16'b11_0011, 16'b11_1101, 6, 8'h4F);

    // Over-length burst: eight original zeros, then the two serial-in ones
    do_burst("overlen", 8'h00, 4'd10, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0300, 10, 8'hFF);

    // Zero-length burst
    en = 1'b1; mode = 3'd0; start = 1'b1; par_in = 8'h5A; burst_len = 4'd0; burst_dir = 1'b0;
    step();
    start = 1'b0;
    chk("len0 par_out", par_out, 8'h5A);
    chk("len0 busy", busy, 1'b0);
    chk("len0 done", done, 1'b1);
    step();
    chk("len0 done_clear", done, 1'b0);
    chk("len0 busy_after", busy, 1'b0);

    // Start during burst is dropped; exactly one done follows
    begin
      int ndone;
      en = 1'b1; mode = 3'd0; start = 1'b1; par_in = 8'h0F; burst_len = 4'd3;
      burst_dir = 1'b0; ser_inr = 1'b0;
      step();
      start = 1'b0;
      step();
      start = 1'b1; par_in = 8'hFF; burst_len = 4'd5; mode = 3'd3;
      step();
      start = 1'b0; mode = 3'd0;
      chk("restart par_out", par_out, 8'h03);
      chk("restart busy", busy, 1'b1);
      step();
      chk("restart final", par_out, 8'h01);
      chk("restart done", done, 1'b1);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (done) ndone++;
      end
      chk("restart extra_done", ndone, 0);
      chk("restart busy_after", busy, 1'b0);
      chk("restart held", par_out, 8'h01);
    end

    // Reset mid-burst
    en = 1'b1; mode = 3'd0; start = 1'b1; par_in = 8'hA5; burst_len = 4'd8; burst_dir = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("midrst pre busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst par_out", par_out, 8'h00);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst ser_outr", ser_outr, 1'b0);
    rst = 1'b0; mode = 3'd0;
    step();
    chk("midrst hold", par_out, 8'h00);
    chk("midrst busy_after", busy, 1'b0);
    step();
    chk("midrst no_done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
